leitor_memoria: RTL

Read-side counterpart of the pixel-memory writer. On a `start` pulse it reads `N_BITS` consecutive 1-bit entries from the 4096×1 video memory, beginning at a base address. It issues one read per cycle through the memory's read port and packs the returned bits into a word that the processor or VGA datapath can consume. Completion is signalled with a single-cycle `done` pulse.

---
 rtl/leitor_memoria_pkg.sv | 27 ++
 rtl/leitor_memoria_linha_atraso.sv | 37 +++
 rtl/leitor_memoria.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/leitor_memoria_pkg.sv
// Shared definitions for the video-memory reader/writer pair: geometry of the
// 4096x1 pixel memory and the transaction state encoding.
package leitor_pkg;

  localparam int unsigned ADDR_W    = 12;
  localparam int unsigned MEM_DEPTH = 4096;
  localparam int unsigned IDX_W     = 5;
  localparam int unsigned WORD_W    = 32;

  typedef enum logic [1:0] {
    IDLE,
    LEITURA,
    ESPERA,
    CONCLUI
  } estado_t;

  // Mask with the n least-significant bits set (n = 0..32).
  function automatic logic [WORD_W-1:0] mascara_bits(input int unsigned n);
    logic [WORD_W-1:0] m;
    m = '0;
    for (int unsigned i = 0; i < WORD_W; i++) begin
      if (i < n) m[i] = 1'b1;
    end
    return m;
  endfunction

endpackage

// File: rtl/leitor_memoria_linha_atraso.sv
// Fixed-length delay line that travels alongside the memory read pipeline,
// carrying the valid flag and bit index of each issued read.
module linha_atraso #(
  parameter int unsigned ESTAGIOS = 2,
  parameter int unsigned LARGURA  = 6
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [LARGURA-1:0] din,
  output logic [LARGURA-1:0] dout
);

  logic [LARGURA-1:0] estagio_q [ESTAGIOS];
  logic [LARGURA-1:0] estagio_d [ESTAGIOS];

  always_comb begin
    estagio_d[0] = din;
    for (int unsigned i = 1; i < ESTAGIOS; i++) begin
      estagio_d[i] = estagio_q[i-1];
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < ESTAGIOS; i++) begin
        estagio_q[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < ESTAGIOS; i++) begin
        estagio_q[i] <= estagio_d[i];
      end
    end
  end

  assign dout = estagio_q[ESTAGIOS-1];

endmodule

// File: rtl/leitor_memoria.sv
// Reads N_BITS consecutive 1-bit entries from the video memory starting at a
// base address and packs them LSB-first into dados_out, then pulses done.
module leitor_memoria
  import leitor_pkg::*;
#(
  parameter int unsigned N_BITS     = 32,
  parameter int unsigned RD_LATENCY = 2
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                start,
  input  logic [31:0]         endereco_base,
  input  logic                q_in,
  output logic [ADDR_W-1:0]   rdaddress,
  output logic                rden,
  output logic [WORD_W-1:0]   dados_out,
  output logic                done,
  output logic                ocupado
);

  localparam logic [WORD_W-1:0] MASCARA = mascara_bits(N_BITS);
  localparam logic [IDX_W-1:0]  IDX_FIM = IDX_W'(N_BITS - 1);
  localparam logic [1:0]        ESP_FIM = 2'(RD_LATENCY - 1);

  estado_t             estado_q, estado_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [1:0]          espera_q, espera_d;
  logic [ADDR_W-1:0]   rdaddress_q, rdaddress_d;
  logic                rden_q, rden_d;
  logic [WORD_W-1:0]   asm_q, asm_d;
  logic [WORD_W-1:0]   dados_q, dados_d;
  logic                done_q, done_d;
  logic                ocupado_q, ocupado_d;

  logic [IDX_W:0]      ret_bus;
  logic                ret_valid;
  logic [IDX_W-1:0]    ret_idx;
  logic                unused_end_alto;

  assign unused_end_alto = ^endereco_base[31:ADDR_W];

  // Each return is steered by the index that was issued with its address.
  linha_atraso #(
    .ESTAGIOS (RD_LATENCY),
    .LARGURA  (IDX_W + 1)
  ) u_linha_atraso (
    .clock (clock),
    .reset (reset),
    .din   ({rden_q, idx_q}),
    .dout  (ret_bus)
  );

  assign {ret_valid, ret_idx} = ret_bus;

  always_comb begin
    estado_d    = estado_q;
    idx_d       = idx_q;
    espera_d    = espera_q;
    rdaddress_d = rdaddress_q;
    rden_d      = rden_q;
    dados_d     = dados_q;
    done_d      = 1'b0;
    ocupado_d   = ocupado_q;

    asm_d = asm_q;
    if (ret_valid) asm_d[ret_idx] = q_in;

    case (estado_q)
      IDLE: begin
        if (start) begin
          estado_d    = LEITURA;
          idx_d       = '0;
          asm_d       = '0;
          rden_d      = 1'b1;
          rdaddress_d = endereco_base[ADDR_W-1:0];
          ocupado_d   = 1'b1;
        end
      end
      LEITURA: begin
        if (idx_q == IDX_FIM) begin
          estado_d = ESPERA;
          rden_d   = 1'b0;
          espera_d = '0;
        end else begin
          idx_d       = idx_q + 1'b1;
          rdaddress_d = rdaddress_q + 1'b1;
        end
      end
      ESPERA: begin
        // The final return is captured on the same edge that publishes the word.
        if (espera_q == ESP_FIM) begin
          estado_d = CONCLUI;
          done_d   = 1'b1;
          dados_d  = asm_d & MASCARA;
        end else begin
          espera_d = espera_q + 1'b1;
        end
      end
      CONCLUI: begin
        estado_d  = IDLE;
        ocupado_d = 1'b0;
      end
      default: begin
        estado_d  = IDLE;
        rden_d    = 1'b0;
        ocupado_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado_q    <= IDLE;
      idx_q       <= '0;
      espera_q    <= '0;
      rdaddress_q <= '0;
      rden_q      <= 1'b0;
      asm_q       <= '0;
      dados_q     <= '0;
      done_q      <= 1'b0;
      ocupado_q   <= 1'b0;
    end else begin
      estado_q    <= estado_d;
      idx_q       <= idx_d;
      espera_q    <= espera_d;
      rdaddress_q <= rdaddress_d;
      rden_q      <= rden_d;
      asm_q       <= asm_d;
      dados_q     <= dados_d;
      done_q      <= done_d;
      ocupado_q   <= ocupado_d;
    end
  end

  assign rdaddress = rdaddress_q;
  assign rden      = rden_q;
  assign dados_out = dados_q;
  assign done      = done_q;
  assign ocupado   = ocupado_q;

endmodule
